// File: rtl/ram16_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths,
// FSM state encoding and owner/pointer encoding.
package ram16_arbiter_pkg;

   localparam int DW_DEF = 32;   // data width
   localparam int AW_DEF = 4;    // address width (16 words)

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // owner / priority pointer encoding
   localparam logic OWN_A = 1'b0;
   localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/ram16_arbiter_rr_pick2.sv
// Two-way round-robin pick. ptr selects the favoured side on a tie
// (0 = A, 1 = B); a lone requester always wins.
module rr_pick2 (
   input  logic req_a,
   input  logic req_b,
   input  logic ptr,
   output logic grant_b
);

   assign grant_b = req_b & (~req_a | ptr);

endmodule

// File: rtl/ram16_arbiter.sv
// Two requesters sharing one single-port RAM. Each access walks
// IDLE -> ACCESS -> DONE; the winner is latched in IDLE and only its
// request fields reach the RAM. Round-robin on simultaneous requests.
module ram16_arbiter
   import ram16_arbiter_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_a,
   input  logic          req_b,
   input  logic          wr_a,
   input  logic          wr_b,
   input  logic [AW-1:0] addr_a,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] wdata_a,
   input  logic [DW-1:0] wdata_b,
   output logic          ack_a,
   output logic          ack_b,
   output logic [DW-1:0] rdata,
   output logic          ram_en,
   output logic          ram_read,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_in,
   input  logic [DW-1:0] ram_out
);

   state_t state_q, state_d;
   logic   owner_q;      // 0 = A, 1 = B
   logic   ptr_q;        // side favoured on the next tie
   logic   grant_b;
   logic [DW-1:0] rdata_q;

   // requester fields packed by side so the owner bit indexes them
   logic [1:0]         req_wr;
   logic [1:0][AW-1:0] req_addr;
   logic [1:0][DW-1:0] req_wdata;
   logic               wr_o;

   assign req_wr    = {wr_b, wr_a};
   assign req_addr  = {addr_b, addr_a};
   assign req_wdata = {wdata_b, wdata_a};
   assign wr_o      = req_wr[owner_q];
   assign rdata     = rdata_q;

   rr_pick2 u_pick (
      .req_a   (req_a),
      .req_b   (req_b),
      .ptr     (ptr_q),
      .grant_b (grant_b)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // owner latch, round-robin pointer and read-data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q <= OWN_A;
         ptr_q   <= OWN_A;
         rdata_q <= '0;
      end else begin
         if (state_q == IDLE && (req_a || req_b)) owner_q <= grant_b;
         // reads complete at the end of ACCESS; writes leave rdata alone
         if (state_q == ACCESS && !wr_o)          rdata_q <= ram_out;
         if (state_q == DONE)                     ptr_q   <= ~owner_q;
      end
   end

   // next state and Moore outputs; RAM port idles at read/addr 0
   always_comb begin
      state_d  = state_q;
      ram_en   = 1'b0;
      ram_read = 1'b1;
      ram_addr = '0;
      ram_in   = '0;
      ack_a    = 1'b0;
      ack_b    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_a || req_b) state_d = ACCESS;
         end
         ACCESS: begin
            ram_en   = 1'b1;
            ram_read = ~wr_o;
            ram_addr = req_addr[owner_q];
            ram_in   = req_wdata[owner_q];
            state_d  = DONE;
         end
         DONE: begin
            ack_a   = (owner_q == OWN_A);
            ack_b   = (owner_q == OWN_B);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram16_arbiter.sv
// Directed bench for ram16_arbiter with a behavioural 16x32 RAM
// (combinational read, write on the clock edge while enabled).
module tb_ram16_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_a, req_b, wr_a, wr_b;
   logic [3:0]  addr_a, addr_b;
   logic [31:0] wdata_a, wdata_b;
   logic        ack_a, ack_b;
   logic [31:0] rdata;
   logic        ram_en, ram_read;
   logic [3:0]  ram_addr;
   logic [31:0] ram_in, ram_out;

   logic [31:0] mem [16];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram16_arbiter dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
      .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
      .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata),
      .ram_en(ram_en), .ram_read(ram_read), .ram_addr(ram_addr),
      .ram_in(ram_in), .ram_out(ram_out)
   );

   // RAM model
   always @(posedge clk) if (ram_en && !ram_read) mem[ram_addr] <= ram_in;
   assign ram_out = mem[ram_addr];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // lone A access: check the ACCESS cycle and ack, then return to IDLE
   task automatic access_a(input logic wr, input logic [3:0] a, input logic [31:0] d, input string tag);
      req_a = 1'b1; wr_a = wr; addr_a = a; wdata_a = d;
      tick;
      chk({tag, ".en"},   {31'd0, ram_en},   32'd1);
      chk({tag, ".rd"},   {31'd0, ram_read}, {31'd0, ~wr});
      chk({tag, ".addr"}, {28'd0, ram_addr}, {28'd0, a});
      tick;
      chk({tag, ".ack_a"}, {31'd0, ack_a}, 32'd1);
      chk({tag, ".ack_b"}, {31'd0, ack_b}, 32'd0);
      req_a = 1'b0;
      tick;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      reset = 1'b1;
      req_a = 1'b0; req_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
      addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
      tick; tick;

      // reset state
      chk("rst.ack_a",    {31'd0, ack_a},    32'd0);
      chk("rst.ack_b",    {31'd0, ack_b},    32'd0);
      chk("rst.ram_en",   {31'd0, ram_en},   32'd0);
      chk("rst.ram_read", {31'd0, ram_read}, 32'd1);
      chk("rst.ram_addr", {28'd0, ram_addr}, 32'd0);
      chk("rst.rdata",    rdata,             32'd0);
      reset = 1'b0;
      tick;

      // A writes DEADBEEF to address 5
      req_a = 1'b1; wr_a = 1'b1; addr_a = 4'd5; wdata_a = 32'hDEADBEEF;
      tick;
      chk("wr5.en",    {31'd0, ram_en},   32'd1);
      chk("wr5.rd",    {31'd0, ram_read}, 32'd0);
      chk("wr5.addr",  {28'd0, ram_addr}, 32'd5);
      chk("wr5.in",    ram_in,            32'hDEADBEEF);
      chk("wr5.noack", {31'd0, ack_a},    32'd0);
      tick;
      chk("wr5.en_off", {31'd0, ram_en}, 32'd0);
      chk("wr5.ack_a",  {31'd0, ack_a},  32'd1);
      chk("wr5.ack_b",  {31'd0, ack_b},  32'd0);
      req_a = 1'b0;
      tick;
      chk("wr5.ack_gone", {31'd0, ack_a}, 32'd0);

      // B reads address 5
      req_b = 1'b1; wr_b = 1'b0; addr_b = 4'd5;
      tick;
      chk("rd5.en",   {31'd0, ram_en},   32'd1);
      chk("rd5.rd",   {31'd0, ram_read}, 32'd1);
      chk("rd5.addr", {28'd0, ram_addr}, 32'd5);
      tick;
      chk("rd5.ack_b", {31'd0, ack_b}, 32'd1);
      chk("rd5.ack_a", {31'd0, ack_a}, 32'd0);
      chk("rd5.rdata", rdata,          32'hDEADBEEF);
      req_b = 1'b0;
      tick;

      // both held: pointer favours A (last owner B), grants alternate
      req_a = 1'b1; wr_a = 1'b1; addr_a = 4'd3; wdata_a = 32'h11;
      req_b = 1'b1; wr_b = 1'b1; addr_b = 4'd4; wdata_b = 32'h22;
      for (int k = 0; k < 4; k++) begin
         tick;
         chk("alt.addr", {28'd0, ram_addr}, (k % 2 == 0) ? 32'd3 : 32'd4);
         chk("alt.in",   ram_in,            (k % 2 == 0) ? 32'h11 : 32'h22);
         tick;
         chk("alt.ack_a", {31'd0, ack_a}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("alt.ack_b", {31'd0, ack_b}, (k % 2 == 0) ? 32'd0 : 32'd1);
         if (k == 3) begin req_a = 1'b0; req_b = 1'b0; end
         tick;
      end

      // lone A so the pointer moves to B, then reset during B's access
      access_a(1'b1, 4'd3, 32'h33, "ptrb");
      req_a = 1'b1; req_b = 1'b1;
      tick;
      chk("rstmid.owner_b", {28'd0, ram_addr}, 32'd4);
      reset = 1'b1;
      tick;
      chk("rstmid.en",    {31'd0, ram_en}, 32'd0);
      chk("rstmid.ack_a", {31'd0, ack_a},  32'd0);
      chk("rstmid.ack_b", {31'd0, ack_b},  32'd0);
      reset = 1'b0;
      tick;
      chk("rstmid.grant_a", {28'd0, ram_addr}, 32'd3);
      tick;
      chk("rstmid.ack_a2", {31'd0, ack_a}, 32'd1);
      chk("rstmid.ack_b2", {31'd0, ack_b}, 32'd0);
      req_a = 1'b0; req_b = 1'b0;
      tick;

      // boundary addresses
      access_a(1'b1, 4'd15, 32'h1, "w15");
      access_a(1'b1, 4'd0,  32'h2, "w0");
      access_a(1'b0, 4'd15, 32'h0, "r15");
      chk("r15.rdata", rdata, 32'h1);
      access_a(1'b0, 4'd0,  32'h0, "r0");
      chk("r0.rdata", rdata, 32'h2);
      access_a(1'b1, 4'd7, 32'h77, "w7");
      chk("w7.rdata_hold", rdata, 32'h2);

      // B pulses for one cycle while A is in ACCESS
      req_a = 1'b1; wr_a = 1'b1; addr_a = 4'd8; wdata_a = 32'h88;
      tick;
      req_b = 1'b1; wr_b = 1'b1; addr_b = 4'd9;
      tick;
      req_b = 1'b0;
      chk("pulse.ack_a", {31'd0, ack_a}, 32'd1);
      chk("pulse.ack_b", {31'd0, ack_b}, 32'd0);
      req_a = 1'b0;
      tick;
      chk("pulse.idle_en", {31'd0, ram_en}, 32'd0);
      tick;
      chk("pulse.no_grant", {31'd0, ram_en}, 32'd0);
      tick;
      chk("pulse.ack_b2", {31'd0, ack_b}, 32'd0);
      chk("pulse.mem9",   mem[9],          32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
